// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, pixel/colour types and small helpers
// for the VGA raster timing controller and its pixel-source interface.
package vga_timing_pkg;

  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_H_VALID = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;
  localparam int VGA_V_VALID = 480;
  localparam int VGA_V_FRONT = 10;
  localparam bit VGA_SYNC_POL = 1'b0;
  localparam int VGA_PIX_LAT  = 1;

  localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BACK + VGA_H_VALID + VGA_H_FRONT;
  localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BACK + VGA_V_VALID + VGA_V_FRONT;
  localparam int VGA_HA_START = VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_HA_END   = VGA_HA_START + VGA_H_VALID;
  localparam int VGA_VA_START = VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_VA_END   = VGA_VA_START + VGA_V_VALID;

  typedef logic [9:0]  pix_coord_t;
  typedef logic [11:0] rgb_t;

  localparam pix_coord_t NO_REQ = 10'h3FF;

  localparam rgb_t RED     = 12'hF00;
  localparam rgb_t GREEN   = 12'h0F0;
  localparam rgb_t BLUE    = 12'h00F;
  localparam rgb_t YELLOW  = 12'hFF0;
  localparam rgb_t CYAN    = 12'h0FF;
  localparam rgb_t MAGENTA = 12'hF0F;
  localparam rgb_t WHITE   = 12'hFFF;
  localparam rgb_t GRAY    = 12'h888;
  localparam rgb_t BLACK   = 12'h000;

  // Half-open interval test [lo, hi)
  function automatic logic in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-source link: the timing master issues coordinates, the picture
// generator answers with RGB444 data a fixed number of clocks later.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  pix_coord_t pix_x;
  pix_coord_t pix_y;
  rgb_t       pix_data;

  modport master (output pix_x, output pix_y, input  pix_data);
  modport slave  (input  pix_x, input  pix_y, output pix_data);

endinterface

// File: rtl/vga_mod_counter.sv
// Modulo-MOD enabled counter with a combinational wrap pulse, used for both
// the horizontal (pixel) and vertical (line) raster counters.
module vga_mod_counter #(
  parameter int MOD = 800,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_o  = en_i && (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing master: sync generation, pixel coordinate requests ahead
// of the visible window by PIX_LAT clocks, and gating of returned pixel data.
module vga_timing_ctrl import vga_timing_pkg::*; #(
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int H_VALID  = VGA_H_VALID,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int V_VALID  = VGA_V_VALID,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int PIX_LAT  = VGA_PIX_LAT
) (
  input  logic                     vga_clk,
  input  logic                     sys_rst_n,
  vga_timing_ctrl_if.master        pix_if,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     rgb_valid,
  output logic [11:0]              rgb,
  output logic                     frame_start
);

  localparam int H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HA_START  = H_SYNC + H_BACK;
  localparam int HA_END    = HA_START + H_VALID;
  localparam int VA_START  = V_SYNC + V_BACK;
  localparam int VA_END    = VA_START + V_VALID;
  localparam int REQ_START = HA_START - PIX_LAT;
  localparam int REQ_END   = HA_END - PIX_LAT;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);

  logic [HW-1:0] cnt_h;
  logic [VW-1:0] cnt_v;
  logic          h_wrap;
  logic          unused_v_wrap;

  vga_mod_counter #(.MOD(H_TOTAL), .W(HW)) u_cnt_h (
    .clk_i   (vga_clk),
    .rst_ni  (sys_rst_n),
    .en_i    (1'b1),
    .count_o (cnt_h),
    .wrap_o  (h_wrap)
  );

  vga_mod_counter #(.MOD(V_TOTAL), .W(VW)) u_cnt_v (
    .clk_i   (vga_clk),
    .rst_ni  (sys_rst_n),
    .en_i    (h_wrap),
    .count_o (cnt_v),
    .wrap_o  (unused_v_wrap)
  );

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       rgb_valid_q, rgb_valid_d;
  logic       frame_start_q, frame_start_d;
  pix_coord_t pix_x_q, pix_x_d;
  pix_coord_t pix_y_q, pix_y_d;
  logic       v_act;

  always_comb begin
    v_act         = in_range(int'(cnt_v), VA_START, VA_END);
    hsync_d       = (int'(cnt_h) < H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (int'(cnt_v) < V_SYNC) ? SYNC_POL : ~SYNC_POL;
    rgb_valid_d   = v_act && in_range(int'(cnt_h), HA_START, HA_END);
    frame_start_d = (cnt_h == '0) && (cnt_v == '0);
    pix_x_d       = NO_REQ;
    pix_y_d       = NO_REQ;
    // Requests run PIX_LAT clocks ahead so data lands on the visible column
    if (v_act && in_range(int'(cnt_h), REQ_START, REQ_END)) begin
      pix_x_d = pix_coord_t'(int'(cnt_h) - REQ_START);
      pix_y_d = pix_coord_t'(int'(cnt_v) - VA_START);
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= NO_REQ;
      pix_y_q       <= NO_REQ;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_valid_q   <= rgb_valid_d;
      frame_start_q <= frame_start_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign rgb_valid    = rgb_valid_q;
  assign frame_start  = frame_start_q;
  assign pix_if.pix_x = pix_x_q;
  assign pix_if.pix_y = pix_y_q;
  assign rgb          = rgb_valid_q ? pix_if.pix_data : BLACK;

endmodule
